// File: rtl/rom_pkg.sv
// ---------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the ROM burst reader slice.
//   - ROM_ADDR_W / ROM_DATA_W : default address and word widths
//   - state_t                 : burst FSM state encoding (IDLE, RUN, DRAIN)
//   - burst_overflows()       : range check used when address wrap is off
// Ports: none (package).
// ---------------------------------------------------------------------------
package rom_pkg;

    localparam int ROM_ADDR_W = 5;
    localparam int ROM_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // True when a burst of 'len' words starting at 'base' would run past
    // the top of a 'depth'-word array.
    function automatic logic burst_overflows(input int base,
                                             input int len,
                                             input int depth);
        return (base + len) > depth;
    endfunction

endpackage

// File: rtl/rom_sync.sv
// ---------------------------------------------------------------------------
// rom_sync
// Single-port ROM with a registered read: q updates on the rising edge of
// clock whenever rden is high, so data appears one cycle after the request.
// The array is filled with its own (truncated) address at elaboration,
// giving the image mem[i] = i mod 2**DATA_W.
// Ports:
//   address : word address of the read
//   clock   : read clock
//   rden    : read enable, address captured on the same edge
//   q       : read data, valid the cycle after rden
// ---------------------------------------------------------------------------
module rom_sync
    import rom_pkg::*;
#(
    parameter int    ADDR_W    = ROM_ADDR_W,
    parameter int    DATA_W    = ROM_DATA_W,
    parameter string INIT_FILE = "rom_init.hex"
) (
    input  logic [ADDR_W-1:0] address,
    input  logic              clock,
    input  logic              rden,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // ROM image, built once at elaboration.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DATA_W'(i);
        end
    end

    // Registered read port; q holds its value when no read is requested.
    always_ff @(posedge clock) begin
        if (rden) begin
            q <= mem[address];
        end
    end

endmodule

// File: rtl/rom_burst_reader.sv
// ---------------------------------------------------------------------------
// rom_burst_reader
// Reads a burst of consecutive ROM words and streams them out over a
// valid/ready interface through a 2-entry skid buffer.
// Configuration macro: ROM_WRAP_EN
//   defined   : addresses wrap modulo DEPTH, any len is accepted, err is 0
//   undefined : a request with base_addr + len > DEPTH pulses err and is
//               dropped without issuing any reads
// Ports:
//   clock     : single clock, rising edge
//   reset_n   : asynchronous active-low reset
//   start     : burst request, only looked at while idle
//   base_addr : first word address, captured with start
//   len       : word count 0..DEPTH, captured with start
//   busy      : high while a burst is active
//   q_valid   : q_data holds a word
//   q_ready   : consumer accepts the word (transfer = q_valid & q_ready)
//   q_data    : output word
//   q_last    : marks the final word of the burst
//   done      : one-cycle pulse after the final word transfers
//   err       : one-cycle pulse on a rejected request
// ---------------------------------------------------------------------------
module rom_burst_reader
    import rom_pkg::*;
#(
    parameter int    ADDR_W    = ROM_ADDR_W,
    parameter int    DATA_W    = ROM_DATA_W,
    parameter string INIT_FILE = "rom_init.hex"
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              q_valid,
    input  logic              q_ready,
    output logic [DATA_W-1:0] q_data,
    output logic              q_last,
    output logic              done,
    output logic              err
);

    localparam int            DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEN_ZERO = '0;
    localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W:0]     remaining;
    logic                done_r;
    logic                err_r;

    logic                rd_pending;
    logic                pending_last;
    logic [DATA_W-1:0]   buf_data [2];
    logic [1:0]          buf_last;
    logic [1:0]          count;

    logic [DATA_W-1:0]   rom_q;

    logic                accept;
    logic                range_bad;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_last;
    logic                pop;
    logic [1:0]          after_pop;
    logic [1:0]          occupancy;
    logic                room;

    rom_sync #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .INIT_FILE(INIT_FILE)
    ) u_rom (
        .address(rd_addr),
        .clock  (clock),
        .rden   (rd_en),
        .q      (rom_q)
    );

    // Buffer bookkeeping. The word leaving this cycle is already subtracted,
    // so with q_ready held high a new read can issue every cycle while the
    // buffered + in-flight total never exceeds two.
    always_comb begin
        pop       = (count != 2'd0) && q_ready;
        after_pop = count - {1'b0, pop};
        occupancy = after_pop + {1'b0, rd_pending};
        room      = (occupancy < 2'd2);
    end

    // Read issue. The first read goes out in the same cycle the request is
    // accepted, which is what puts the first word on q two cycles after
    // start. Later reads come from the address counter while in RUN.
    always_comb begin
        accept    = 1'b0;
        range_bad = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = addr_cnt;
        rd_last   = 1'b0;
`ifndef ROM_WRAP_EN
        range_bad = burst_overflows(int'(base_addr), int'(len), DEPTH);
`endif
        if (state == IDLE && start) begin
            accept = 1'b1;
            if (len != LEN_ZERO && !range_bad) begin
                rd_en   = 1'b1;
                rd_addr = base_addr;
                rd_last = (len == LEN_ONE);
            end
        end else if (state == RUN && room) begin
            rd_en   = 1'b1;
            rd_addr = addr_cnt;
            rd_last = (remaining == LEN_ONE);
        end
    end

    // Burst FSM with registered done/err pulses. A one-word burst goes
    // straight to DRAIN because its only read issued on acceptance.
    // Address arithmetic is ADDR_W bits wide, so it wraps at DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (len == LEN_ZERO) begin
                            done_r <= 1'b1;
                        end else if (range_bad) begin
                            err_r <= 1'b1;
                        end else begin
                            addr_cnt  <= base_addr + 1'b1;
                            remaining <= len - LEN_ONE;
                            state     <= (len == LEN_ONE) ? DRAIN : RUN;
                        end
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        addr_cnt  <= addr_cnt + 1'b1;
                        remaining <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && buf_last[0]) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Skid buffer. Entry 0 is always the head presented on q; when both
    // entries are full and the head leaves, entry 1 shifts down. A word
    // arriving from the ROM lands in the first free slot after the pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending   <= 1'b0;
            pending_last <= 1'b0;
            buf_data[0]  <= '0;
            buf_data[1]  <= '0;
            buf_last     <= 2'b00;
            count        <= 2'd0;
        end else begin
            rd_pending   <= rd_en;
            pending_last <= rd_last;
            if (pop && count == 2'd2) begin
                buf_data[0] <= buf_data[1];
                buf_last[0] <= buf_last[1];
            end
            if (rd_pending) begin
                buf_data[after_pop[0]] <= rom_q;
                buf_last[after_pop[0]] <= pending_last;
            end
            count <= occupancy;
        end
    end

    assign busy    = (state != IDLE);
    assign q_valid = (count != 2'd0);
    assign q_data  = buf_data[0];
    assign q_last  = q_valid & buf_last[0];
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_rom_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_burst_reader
// Directed, table-driven bench for rom_burst_reader (ADDR_W=5, DATA_W=4,
// built-in image mem[i] = i mod 16). Each table record holds the inputs for
// one cycle and the outputs expected during that cycle. Hand-written
// sequences cover reset behaviour. Honours ROM_WRAP_EN like the design.
// ---------------------------------------------------------------------------
module tb_rom_burst_reader;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [4:0] base_addr;
    logic [5:0] len;
    logic       busy;
    logic       q_valid;
    logic       q_ready;
    logic [3:0] q_data;
    logic       q_last;
    logic       done;
    logic       err;

    typedef struct {
        logic       start;
        logic [4:0] base;
        logic [5:0] len;
        logic       ready;
        logic       busy;
        logic       valid;
        logic [3:0] data;
        logic       last;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    rom_burst_reader #(
        .ADDR_W   (5),
        .DATA_W   (4),
        .INIT_FILE("")
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_data   (q_data),
        .q_last   (q_last),
        .done     (done),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input int s, input int b, input int l,
                                input int r, input int bz, input int v,
                                input int d, input int la, input int dn,
                                input int e);
        vec_t t;
        t.start = 1'(s);
        t.base  = 5'(b);
        t.len   = 6'(l);
        t.ready = 1'(r);
        t.busy  = 1'(bz);
        t.valid = 1'(v);
        t.data  = 4'(d);
        t.last  = 1'(la);
        t.done  = 1'(dn);
        t.err   = 1'(e);
        return t;
    endfunction

    task automatic check_output(input string name, input int step,
                                input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s at step %0d: got %0h, expected %0h",
                     name, step, act, exp);
        end
    endtask

    // Drive one cycle's inputs, compare the registered outputs, advance.
    task automatic apply_stimulus(input vec_t v, input int step);
        start     = v.start;
        base_addr = v.base;
        len       = v.len;
        q_ready   = v.ready;
        check_output("busy",    step, 32'(busy),    32'(v.busy));
        check_output("q_valid", step, 32'(q_valid), 32'(v.valid));
        check_output("q_last",  step, 32'(q_last),  32'(v.last));
        check_output("done",    step, 32'(done),    32'(v.done));
        check_output("err",     step, 32'(err),     32'(v.err));
        if (v.valid) begin
            check_output("q_data", step, 32'(q_data), 32'(v.data));
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input int step);
        check_output("rst_busy",    step, 32'(busy),    32'd0);
        check_output("rst_q_valid", step, 32'(q_valid), 32'd0);
        check_output("rst_q_last",  step, 32'(q_last),  32'd0);
        check_output("rst_done",    step, 32'(done),    32'd0);
        check_output("rst_err",     step, 32'(err),     32'd0);
        check_output("rst_q_data",  step, 32'(q_data),  32'd0);
    endtask

    initial begin
        // args: start, base, len, ready | busy, valid, data, last, done, err
        // Basic burst base=0 len=4
        vecs.push_back(mk(1, 0, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // Backpressure base=2 len=3, ready low for three cycles
        vecs.push_back(mk(1, 2, 3, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // Start while busy is ignored: burst base=0 len=2
        vecs.push_back(mk(1, 0, 2, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10, 5, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10, 5, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // Zero length: done only
        vecs.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // Top word, exactly fits: base=31 len=1
        vecs.push_back(mk(1, 31, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 15, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
`ifdef ROM_WRAP_EN
        // Wrap base=30 len=4 -> 14,15,0,1
        vecs.push_back(mk(1, 30, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 14, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 15, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
`else
        // Out of range base=30 len=4 -> err, no reads
        vecs.push_back(mk(1, 30, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // Out of range by one: base=1 len=32
        vecs.push_back(mk(1, 1, 32, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
`endif

        // Power-up reset
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        q_ready   = 1'b1;
        #3;
        check_all_zero(-1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Reset mid-burst after the second word
        apply_stimulus(mk(1, 0, 4, 1, 0, 0, 0, 0, 0, 0), 1000);
        apply_stimulus(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1001);
        apply_stimulus(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0), 1002);
        apply_stimulus(mk(0, 0, 0, 1, 1, 1, 1, 0, 0, 0), 1003);
        reset_n = 1'b0;
        #1;
        check_all_zero(1004);
        #2;
        reset_n = 1'b1;
        // First burst after release: base=5 len=1
        apply_stimulus(mk(1, 5, 1, 1, 0, 0, 0, 0, 0, 0), 1010);
        apply_stimulus(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1011);
        apply_stimulus(mk(0, 0, 0, 1, 1, 1, 5, 1, 0, 0), 1012);
        apply_stimulus(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0), 1013);
        apply_stimulus(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1014);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
